// File: rtl/cmplx_pkg.sv
// Shared width rule and complex container type for the complex MAC pipeline and its users.
package cmplx_pkg;

    localparam int CPLX_W = 32;

    // Generic-width complex pair; width-generic RTL declares local structs of the same shape.
    typedef struct packed {
        logic signed [CPLX_W-1:0] re;
        logic signed [CPLX_W-1:0] im;
    } cplx_t;

    function automatic int cmplx_ow(input int dw, input int acc_len);
        return 2 * dw + 1 + $clog2(acc_len);
    endfunction

endpackage

// File: rtl/cmplx_mult_stage.sv
// Stages S1..S3 of the complex MAC: operand register with conjugation, partial products, add/sub.
module cmplx_mult_stage #(
    parameter  int DW = 8,
    localparam int PW = 2 * DW + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_en,
    input  logic                 i_flush,
    input  logic                 i_vld,
    input  logic signed [DW-1:0] i_ar,
    input  logic signed [DW-1:0] i_ai,
    input  logic signed [DW-1:0] i_br,
    input  logic signed [DW-1:0] i_bi,
    input  logic                 i_conj,
    output logic                 o_vld,
    output logic signed [PW-1:0] o_re,
    output logic signed [PW-1:0] o_im
);

    logic                 r_vld_p1, r_vld_p2, r_vld_p3;
    logic signed [DW-1:0] r_ar_p1, r_ai_p1, r_br_p1;
    logic signed [DW:0]   r_bi_p1;
    logic signed [PW-1:0] r_rr_p2, r_ii_p2, r_ri_p2, r_ir_p2;
    logic signed [PW-1:0] r_re_p3, r_im_p3;
    logic signed [DW:0]   w_bi_ext;

    // One extra bit so negating the most negative b_imag stays exact.
    assign w_bi_ext = (DW+1)'(i_bi);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p1 <= 1'b0;
            r_vld_p2 <= 1'b0;
            r_vld_p3 <= 1'b0;
        end else if (i_flush) begin
            r_vld_p1 <= 1'b0;
            r_vld_p2 <= 1'b0;
            r_vld_p3 <= 1'b0;
        end else if (i_en) begin
            r_vld_p1 <= i_vld;
            r_vld_p2 <= r_vld_p1;
            r_vld_p3 <= r_vld_p2;
        end
    end

    always_ff @(posedge clk) begin
        if (i_en) begin
            // S1: operand capture
            r_ar_p1 <= i_ar;
            r_ai_p1 <= i_ai;
            r_br_p1 <= i_br;
            r_bi_p1 <= i_conj ? -w_bi_ext : w_bi_ext;
            // S2: partial products
            r_rr_p2 <= PW'(r_ar_p1) * PW'(r_br_p1);
            r_ii_p2 <= PW'(r_ai_p1) * PW'(r_bi_p1);
            r_ri_p2 <= PW'(r_ar_p1) * PW'(r_bi_p1);
            r_ir_p2 <= PW'(r_ai_p1) * PW'(r_br_p1);
            // S3: combine
            r_re_p3 <= r_rr_p2 - r_ii_p2;
            r_im_p3 <= r_ri_p2 + r_ir_p2;
        end
    end

    assign o_vld = r_vld_p3;
    assign o_re  = r_re_p3;
    assign o_im  = r_im_p3;

endmodule

// File: rtl/cmplx_mac_pipe.sv
// Pipelined complex multiply-accumulate: ACC_LEN products per result, exact width, valid/ready.
module cmplx_mac_pipe
    import cmplx_pkg::*;
#(
    parameter  int DW      = 8,
    parameter  int ACC_LEN = 1,
    localparam int OW      = cmplx_ow(DW, ACC_LEN)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] a_real,
    input  logic signed [DW-1:0] a_imag,
    input  logic signed [DW-1:0] b_real,
    input  logic signed [DW-1:0] b_imag,
    input  logic                 conj_b,
    input  logic                 clear,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [OW-1:0] z_real,
    output logic signed [OW-1:0] z_imag
);

    localparam int PW = 2 * DW + 1;
    localparam int CW = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;

    typedef struct packed {
        logic signed [OW-1:0] re;
        logic signed [OW-1:0] im;
    } acc_t;

    logic                 w_en, w_accept, w_vld_p3;
    logic signed [PW-1:0] w_re_p3, w_im_p3;
    acc_t                 w_prod, w_sum;
    logic [CW-1:0]        r_cnt;
    acc_t                 r_acc_p4, r_z_p5;
    logic                 r_done_p4, r_vld_p5;

    // A held result that nobody takes freezes the entire pipe.
    assign w_en     = !(r_vld_p5 && !out_ready);
    assign in_ready = w_en && !clear;
    assign w_accept = in_valid && in_ready;

    cmplx_mult_stage #(.DW(DW)) u_mult (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (w_en),
        .i_flush (clear),
        .i_vld   (w_accept),
        .i_ar    (a_real),
        .i_ai    (a_imag),
        .i_br    (b_real),
        .i_bi    (b_imag),
        .i_conj  (conj_b),
        .o_vld   (w_vld_p3),
        .o_re    (w_re_p3),
        .o_im    (w_im_p3)
    );

    always_comb begin
        w_prod.re = OW'(w_re_p3);
        w_prod.im = OW'(w_im_p3);
        w_sum     = w_prod;
        if (r_cnt != '0) begin
            w_sum.re = r_acc_p4.re + w_prod.re;
            w_sum.im = r_acc_p4.im + w_prod.im;
        end
    end

    // S4: accumulate; r_done_p4 marks a completed group waiting for the output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_acc_p4  <= '0;
            r_done_p4 <= 1'b0;
        end else if (clear) begin
            r_cnt     <= '0;
            r_acc_p4  <= '0;
            r_done_p4 <= 1'b0;
        end else if (w_en) begin
            r_done_p4 <= 1'b0;
            if (w_vld_p3) begin
                r_acc_p4 <= w_sum;
                if (r_cnt == CW'(ACC_LEN - 1)) begin
                    r_cnt     <= '0;
                    r_done_p4 <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    // S5: output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p5 <= 1'b0;
            r_z_p5   <= '0;
        end else if (w_en) begin
            r_vld_p5 <= r_done_p4 && !clear;
            if (r_done_p4 && !clear) begin
                r_z_p5 <= r_acc_p4;
            end
        end
    end

    assign out_valid = r_vld_p5;
    assign z_real    = r_z_p5.re;
    assign z_imag    = r_z_p5.im;

endmodule

// File: tb/tb_cmplx_mac_pipe.sv
// Bench for cmplx_mac_pipe: ACC_LEN=1 and ACC_LEN=2 instances against an arithmetic reference model.
module tb_cmplx_mac_pipe;
    import cmplx_pkg::*;

    localparam int DW   = 8;
    localparam int OW1  = cmplx_ow(DW, 1);
    localparam int OW2  = cmplx_ow(DW, 2);

    logic clk = 1'b0;
    logic rst_n;
    logic signed [DW-1:0] a_re, a_im, b_re, b_im;
    logic conj_b, clear, out_ready;
    logic in_valid1, in_valid2, in_ready1, in_ready2, out_valid1, out_valid2;
    logic signed [OW1-1:0] z1r, z1i;
    logic signed [OW2-1:0] z2r, z2i;

    int n_vec = 0;
    int n_err = 0;

    cplx_t q1[$];
    cplx_t q2[$];
    int p1re = 0, p1im = 0, p1cnt = 0;
    int p2re = 0, p2im = 0, p2cnt = 0;

    always #5 clk = ~clk;

    cmplx_mac_pipe #(.DW(DW), .ACC_LEN(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .a_real(a_re), .a_imag(a_im), .b_real(b_re), .b_imag(b_im),
        .conj_b(conj_b), .clear(clear), .out_valid(out_valid1), .out_ready(out_ready),
        .z_real(z1r), .z_imag(z1i)
    );

    cmplx_mac_pipe #(.DW(DW), .ACC_LEN(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .a_real(a_re), .a_imag(a_im), .b_real(b_re), .b_imag(b_im),
        .conj_b(conj_b), .clear(clear), .out_valid(out_valid2), .out_ready(out_ready),
        .z_real(z2r), .z_imag(z2i)
    );

    task automatic check(input string tag, input longint obs, input longint exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic cplx_t cmul(input int ar, input int ai, input int br, input int bi, input bit cj);
        cplx_t r;
        int bj;
        bj   = cj ? -bi : bi;
        r.re = ar * br - ai * bj;
        r.im = ar * bj + ai * br;
        return r;
    endfunction

    task automatic set_beat(input int ar, input int ai, input int br, input int bi, input bit cj);
        a_re   = 8'(ar);
        a_im   = 8'(ai);
        b_re   = 8'(br);
        b_im   = 8'(bi);
        conj_b = cj;
    endtask

    task automatic rnd_beat();
        a_re   = 8'($urandom);
        a_im   = 8'($urandom);
        b_re   = 8'($urandom);
        b_im   = 8'($urandom);
        conj_b = 1'($urandom);
    endtask

    task automatic flush_model();
        q1.delete();
        q2.delete();
        p1re = 0; p1im = 0; p1cnt = 0;
        p2re = 0; p2im = 0; p2cnt = 0;
    endtask

    // Reference model and scoreboard, sampled mid-cycle where every input is stable.
    always @(negedge clk) begin
        cplx_t pr, e;
        if (rst_n) begin
            check("rdy1", in_ready1, !(out_valid1 && !out_ready) && !clear);
            check("rdy2", in_ready2, !(out_valid2 && !out_ready) && !clear);
            if (out_valid1 && out_ready) begin
                if (q1.size() == 0) check("extra1", out_valid1, 0);
                else begin
                    e = q1.pop_front();
                    check("z1_re", z1r, e.re);
                    check("z1_im", z1i, e.im);
                end
            end
            if (out_valid2 && out_ready) begin
                if (q2.size() == 0) check("extra2", out_valid2, 0);
                else begin
                    e = q2.pop_front();
                    check("z2_re", z2r, e.re);
                    check("z2_im", z2i, e.im);
                end
            end
            pr = cmul(a_re, a_im, b_re, b_im, conj_b);
            if (clear) begin
                p1re = 0; p1im = 0; p1cnt = 0;
                p2re = 0; p2im = 0; p2cnt = 0;
            end else begin
                if (in_valid1 && in_ready1) begin
                    q1.push_back(pr);
                end
                if (in_valid2 && in_ready2) begin
                    p2re += int'(pr.re);
                    p2im += int'(pr.im);
                    p2cnt++;
                    if (p2cnt == 2) begin
                        e.re = p2re;
                        e.im = p2im;
                        q2.push_back(e);
                        p2re = 0; p2im = 0; p2cnt = 0;
                    end
                end
            end
        end
    end

    task automatic single_lat(input string tag, input int ar, input int ai, input int br,
                              input int bi, input bit cj, input int ere, input int eim);
        set_beat(ar, ai, br, bi, cj);
        in_valid1 = 1'b1;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            check({tag, "_early"}, out_valid1, 0);
        end
        @(posedge clk); #1;
        check({tag, "_vld"}, out_valid1, 1);
        check({tag, "_re"}, z1r, ere);
        check({tag, "_im"}, z1i, eim);
    endtask

    // (3-i)*conj(2+5i) + (-4+6i)*(-7+3i) = (1-17i) + (10-54i) = 11-71i
    task automatic pair_lat2(input string tag);
        set_beat(3, -1, 2, 5, 1);
        in_valid2 = 1'b1;
        @(posedge clk); #1;
        check({tag, "_mid"}, out_valid2, 0);
        set_beat(-4, 6, -7, 3, 0);
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            check({tag, "_early"}, out_valid2, 0);
        end
        @(posedge clk); #1;
        check({tag, "_vld"}, out_valid2, 1);
        check({tag, "_re"}, z2r, 11);
        check({tag, "_im"}, z2i, -71);
    endtask

    initial begin
        rst_n = 1'b0; in_valid1 = 1'b0; in_valid2 = 1'b0; clear = 1'b0; out_ready = 1'b1;
        set_beat(0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_vld1", out_valid1, 0);
        check("rst_z1r", z1r, 0);
        check("rst_z1i", z1i, 0);
        check("rst_vld2", out_valid2, 0);
        check("rst_z2r", z2r, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_rdy1", in_ready1, 1);
        check("rst_rdy2", in_ready2, 1);

        single_lat("m0", 1, 2, 3, 4, 0, -5, 10);
        single_lat("m1", 2, 4, 6, 8, 0, -20, 40);
        single_lat("cj0", 1, 2, 3, 4, 1, 11, 2);
        single_lat("ext0", -128, -128, -128, -128, 0, 0, 32768);
        single_lat("ext1", -128, -128, -128, -128, 1, 32768, 0);
        single_lat("ext2", 1, 0, 0, -128, 1, 0, 128);

        // Back-to-back beats, conj alternating: one result per cycle for eight cycles.
        for (int i = 1; i <= 8; i++) begin
            rnd_beat();
            conj_b    = i[0];
            in_valid1 = 1'b1;
            @(posedge clk); #1;
            if (i >= 5) check("b2b_vld", out_valid1, 1);
        end
        in_valid1 = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            check("b2b_vld", out_valid1, 1);
        end
        @(posedge clk); #1;
        check("b2b_end", out_valid1, 0);

        // Back-pressure: hold out_ready low for five cycles with beats still offered.
        for (int i = 0; i < 4; i++) begin
            rnd_beat();
            in_valid1 = 1'b1;
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        #1;
        check("bp_rdy_pre", in_ready1, 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            rnd_beat();
            check("bp_vld", out_valid1, 1);
            check("bp_rdy", in_ready1, 0);
        end
        out_ready = 1'b1;
        in_valid1 = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("bp_drain", q1.size(), 0);

        for (int i = 0; i < 150; i++) begin
            rnd_beat();
            in_valid1 = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        in_valid1 = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("q1_drain", q1.size(), 0);

        // ACC_LEN=2: (1+2i)(3+4i) + bubble + (2+4i)(6+8i) = -25+50i
        set_beat(1, 2, 3, 4, 0);
        in_valid2 = 1'b1;
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        check("acc_b0", out_valid2, 0);
        @(posedge clk); #1;
        check("acc_bub", out_valid2, 0);
        set_beat(2, 4, 6, 8, 0);
        in_valid2 = 1'b1;
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            check("acc_early", out_valid2, 0);
        end
        @(posedge clk); #1;
        check("acc_vld", out_valid2, 1);
        check("acc_re", z2r, -25);
        check("acc_im", z2i, 50);

        // clear after the first beat of a group, with a beat offered in the clear cycle
        set_beat(5, -3, 7, 2, 0);
        in_valid2 = 1'b1;
        @(posedge clk); #1;
        set_beat(9, 9, 9, 9, 0);
        clear = 1'b1;
        #1;
        check("clr_rdy", in_ready2, 0);
        @(posedge clk); #1;
        clear = 1'b0;
        pair_lat2("clr");

        for (int i = 0; i < 150; i++) begin
            rnd_beat();
            in_valid2 = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        in_valid2 = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("q2_drain", q2.size(), 0);

        // Reset mid-stream with a result parked in the output register.
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rnd_beat();
            in_valid2 = 1'b1;
            @(posedge clk); #1;
        end
        check("prerst_vld", out_valid2, 1);
        #2;
        rst_n = 1'b0;
        flush_model();
        #1;
        check("arst_vld2", out_valid2, 0);
        check("arst_z2r", z2r, 0);
        check("arst_z2i", z2i, 0);
        check("arst_vld1", out_valid1, 0);
        in_valid2 = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_rdy", in_ready2, 1);
        check("post_rst_vld", out_valid2, 0);
        pair_lat2("prst");

        repeat (6) @(posedge clk);
        #1;
        check("fin_q1", q1.size(), 0);
        check("fin_q2", q2.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
